// File: rtl/can_stuff.sv
// CAN transmit bit stuffer: paces one NRZ bit per CLKS_PER_BIT clocks and inserts a complement
// stuff bit after five equal bits. Optional stuff-bit statistics counter: define CAN_STUFF_CNT_EN.
module can_stuff #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_Tx_Valid,
    input  logic       i_Tx_Bit,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Stuff_Active,
`ifdef CAN_STUFF_CNT_EN
    output logic [7:0] o_Stuff_Count,
`endif
    output logic       o_Bit_Tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STUFF
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clock_count_q, clock_count_d;
    logic [2:0]    run_q, run_d;
    logic          last_q, last_d;
    logic          tx_serial_q, tx_serial_d;
    logic          stuff_active_q, stuff_active_d;
    logic          bit_tick_q, bit_tick_d;

    logic boundary;
    logic stuff_pending;

    assign boundary      = (clock_count_q == LAST_COUNT);
    assign stuff_pending = i_Enable && (run_q == 3'd5);
    assign o_Tx_Ready    = boundary && !stuff_pending && !i_Reset;

    assign o_Tx_Serial    = tx_serial_q;
    assign o_Stuff_Active = stuff_active_q;
    assign o_Bit_Tick     = bit_tick_q;

    // All line decisions are made on the last clock of a bit period so the new bit
    // appears together with the bit tick on the first clock of the next period.
    always_comb begin
        state_d        = state_q;
        run_d          = run_q;
        last_d         = last_q;
        tx_serial_d    = tx_serial_q;
        stuff_active_d = stuff_active_q;
        clock_count_d  = boundary ? '0 : clock_count_q + 1'b1;
        bit_tick_d     = boundary;

        if (boundary) begin
            if (stuff_pending) begin
                state_d        = STUFF;
                tx_serial_d    = ~last_q;
                last_d         = ~last_q;
                run_d          = 3'd1;
                stuff_active_d = 1'b1;
            end else if (i_Tx_Valid) begin
                state_d        = DATA;
                tx_serial_d    = i_Tx_Bit;
                stuff_active_d = 1'b0;
                last_d         = i_Tx_Bit;
                if (!i_Enable) begin
                    run_d = 3'd0;
                end else if (i_Tx_Bit == last_q) begin
                    run_d = run_q + 3'd1;
                end else begin
                    run_d = 3'd1;
                end
            end else begin
                state_d        = IDLE;
                tx_serial_d    = 1'b1;
                run_d          = 3'd0;
                last_d         = 1'b1;
                stuff_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q        <= IDLE;
            clock_count_q  <= '0;
            run_q          <= 3'd0;
            last_q         <= 1'b1;
            tx_serial_q    <= 1'b1;
            stuff_active_q <= 1'b0;
            bit_tick_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            clock_count_q  <= clock_count_d;
            run_q          <= run_d;
            last_q         <= last_d;
            tx_serial_q    <= tx_serial_d;
            stuff_active_q <= stuff_active_d;
            bit_tick_q     <= bit_tick_d;
        end
    end

`ifdef CAN_STUFF_CNT_EN
    logic [7:0] stuff_count_q, stuff_count_d;
    logic       enable_prev_q;
    logic       stuff_entry;

    assign stuff_entry   = boundary && stuff_pending;
    assign o_Stuff_Count = stuff_count_q;

    // A rising i_Enable marks a new frame and restarts the statistics.
    always_comb begin
        stuff_count_d = stuff_count_q;
        if (i_Enable && !enable_prev_q) begin
            stuff_count_d = stuff_entry ? 8'd1 : 8'd0;
        end else if (stuff_entry && (stuff_count_q != 8'hFF)) begin
            stuff_count_d = stuff_count_q + 8'd1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            stuff_count_q <= 8'd0;
            enable_prev_q <= 1'b0;
        end else begin
            stuff_count_q <= stuff_count_d;
            enable_prev_q <= i_Enable;
        end
    end
`endif

endmodule
